mem_access_unit: RTL and testbench

//  Load/store bridge between the core and the data bus (DRAM + peripherals). Stalls the core for the whole

---
 rtl/mem_access_unit_pkg.sv | 43 ++++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_load_extend.sv | 28 ++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared access-size codes and store lane helpers for the load/store bridge.
// Imported by the top level and the load extension datapath.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return ((size == SZ_H) && off[0]) ||
               ((size == SZ_W) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] wstrb_of(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] s;
        s = 4'b1111;
        if (size == SZ_B)
            s = 4'b0001 << off;
        else if (size == SZ_H)
            s = off[1] ? 4'b1100 : 4'b0011;
        return s;
    endfunction

    function automatic logic [31:0] wdata_of(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] w;
        w = d;
        if (size == SZ_B)
            w = {4{d[7:0]}};
        else if (size == SZ_H)
            w = {2{d[15:0]}};
        return w;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data bus between the load/store bridge (master) and DRAM/peripherals (slave).
// bus_ack is a one-cycle strobe; bus_rdata is valid in the same cycle.
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load alignment: word, byte offset, size, uns -> right-justified, extended rdo.
// Purely combinational.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdo
);

    logic [31:0] sh;

    assign sh = word >> {off, 3'b000};

    always_comb begin
        rdo = sh;
        case (size)
            SZ_B: rdo = uns ? {24'b0, sh[7:0]}
                            : {{24{sh[7]}}, sh[7:0]};
            SZ_H: rdo = uns ? {16'b0, sh[15:0]}
                            : {{16{sh[15]}}, sh[15:0]};
            default: rdo = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bridge: stalls the core, runs one bus access with strobes,
// and returns aligned load data. Ports: core req_*, stall/rdo/done/
// misalign/bus_err status, and the bus interface (master modport).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdo,
    output logic        done,
    output logic        misalign,
    output logic        bus_err,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic [CNT_W-1:0] wdog;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] ext;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    load_extend u_ext (
        .word (bus.bus_rdata),
        .off  (off_q),
        .size (size_q),
        .uns  (uns_q),
        .rdo  (ext)
    );

    // Request cycle stalls combinationally so the PC freezes at once.
    assign stall = (state == IDLE) ? req_valid : (state == BUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wdog          <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            rdo           <= '0;
            done          <= 1'b0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wstrb <= '0;
            bus.bus_wdata <= '0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q          <= req_we;
                        uns_q         <= req_uns;
                        size_q        <= req_size;
                        off_q         <= req_addr[1:0];
                        rdo           <= '0;
                        bus.bus_we    <= req_we;
                        bus.bus_addr  <= {req_addr[31:2], 2'b00};
                        bus.bus_wstrb <= req_we ?
                            wstrb_of(req_size, req_addr[1:0]) : 4'b0000;
                        bus.bus_wdata <= wdata_of(req_size, req_wdata);
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state       <= BUS;
                            bus.bus_req <= 1'b1;
                            wdog        <= '0;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (bus.bus_ack) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        done        <= 1'b1;
                        rdo         <= we_q ? 32'h0 : ext;
                    end else if (wdog == WD_LAST) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        done        <= 1'b1;
                        bus_err     <= 1'b1;
                        rdo         <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdo   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads, stores, misaligned,
// timeout and mid-access reset; a monitor checks every done strobe.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall;
    logic [31:0] rdo;
    logic        done;
    logic        misalign;
    logic        bus_err;

    mem_access_unit_if bif ();

    mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rdo       (rdo),
        .done      (done),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdo;
        logic        mis;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdo", rdo, e.rdo);
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("bus_err", 32'(bus_err), 32'(e.err));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // ack_dly = 0 means the bus never answers (watchdog path).
    task automatic access(
        input logic        we,
        input logic [1:0]  size,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rdata,
        input int          ack_dly,
        input logic [31:0] exp_rdo,
        input logic        exp_mis,
        input logic        exp_err,
        input logic [31:0] exp_addr,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wdata
    );
        int c0;
        int n;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        c0 = cyc;
        n = (ack_dly == 0) ? 16 : ack_dly;
        e.rdo = exp_rdo;
        e.mis = exp_mis;
        e.err = exp_err;
        e.cyc = exp_mis ? c0 + 1 : c0 + n + 1;
        q.push_back(e);
        @(negedge clk);
        chk("stall_req_cycle", 32'(stall), 32'd1);
        chk("bus_req_req_cycle", 32'(bif.bus_req), 32'd0);
        if (!exp_mis) begin
            for (int i = 1; i <= n; i++) begin
                @(posedge clk); #1;
                if (i == ack_dly) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = rdata;
                end
                @(negedge clk);
                chk("bus_req_busy", 32'(bif.bus_req), 32'd1);
                chk("stall_busy", 32'(stall), 32'd1);
                if (i == 1) begin
                    chk("bus_addr", bif.bus_addr, exp_addr);
                    chk("bus_we", 32'(bif.bus_we), 32'(we));
                    chk("bus_wstrb", 32'(bif.bus_wstrb), 32'(exp_strb));
                    if (we)
                        chk("bus_wdata", bif.bus_wdata, exp_wdata);
                end
            end
        end
        @(posedge clk); #1;
        bif.bus_ack = 1'b0;
        @(negedge clk);
        chk("stall_done", 32'(stall), 32'd0);
        chk("bus_req_done", 32'(bif.bus_req), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_rdo", rdo, 32'd0);
        chk("rst_wstrb", 32'(bif.bus_wstrb), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        #2 rst_n = 1'b1;

        // lb 0x103
        access(0, 2'b00, 0, 32'h103, 0, 32'h8000_0000, 1,
               32'hFFFF_FF80, 0, 0, 32'h100, 4'b0000, 0);
        // lhu 0x102
        access(0, 2'b01, 1, 32'h102, 0, 32'h8001_1234, 1,
               32'h0000_8001, 0, 0, 32'h100, 4'b0000, 0);
        // lw 0x104, slower ack
        access(0, 2'b10, 0, 32'h104, 0, 32'hDEAD_BEEF, 3,
               32'hDEAD_BEEF, 0, 0, 32'h104, 4'b0000, 0);
        // lh 0x100 sign
        access(0, 2'b01, 0, 32'h100, 0, 32'h0000_F234, 2,
               32'hFFFF_F234, 0, 0, 32'h100, 4'b0000, 0);
        // lbu 0x101
        access(0, 2'b00, 1, 32'h101, 0, 32'h0000_A500, 1,
               32'h0000_00A5, 0, 0, 32'h100, 4'b0000, 0);
        // sb 0x201
        access(1, 2'b00, 0, 32'h201, 32'h0000_00AB, 32'h1234_5678, 1,
               32'h0, 0, 0, 32'h200, 4'b0010, 32'hABAB_ABAB);
        // sh 0x202
        access(1, 2'b01, 0, 32'h202, 32'h0000_BEEF, 32'h1234_5678, 2,
               32'h0, 0, 0, 32'h200, 4'b1100, 32'hBEEF_BEEF);
        // sw 0x300
        access(1, 2'b10, 0, 32'h300, 32'hCAFE_F00D, 32'h1234_5678, 1,
               32'h0, 0, 0, 32'h300, 4'b1111, 32'hCAFE_F00D);
        // misaligned lw 0x106, lh 0x101
        access(0, 2'b10, 0, 32'h106, 0, 0, 1,
               32'h0, 1, 0, 32'h0, 4'b0000, 0);
        access(0, 2'b01, 0, 32'h101, 0, 0, 1,
               32'h0, 1, 0, 32'h0, 4'b0000, 0);
        // watchdog timeout
        access(0, 2'b10, 0, 32'h400, 0, 0, 0,
               32'h0, 0, 1, 32'h400, 4'b0000, 0);

        // stray ack while idle
        @(posedge clk); #1;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("stray_bus_req", 32'(bif.bus_req), 32'd0);
        @(posedge clk); #1;
        bif.bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_stall", 32'(stall), 32'd0);
        chk("stray_rdo", rdo, 32'd0);

        // reset in the middle of a bus access
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h500;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_bus_req", 32'(bif.bus_req), 32'd1);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("async_rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        chk("in_rst_done", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        access(0, 2'b10, 0, 32'h504, 0, 32'h0102_0304, 2,
               32'h0102_0304, 0, 0, 32'h504, 4'b0000, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got no finish expected finish before 200000");
        $fatal(1, "time limit");
    end

endmodule
